tqvp_hx2003_pulse_receiver: RTL and testbench

TinyQV peripheral that captures a pulse train on one `ui_in` pin and decodes it into the same 2-bit symbol format the pulse transmitter emits: bit1 = level, bit0 = long/short. Each completed level period is timed by a prescaled counter and classified against per-level thresholds. The symbol is packed into a 128-symbol buffer (8 × 32-bit words) that the CPU reads back. The frame ends on idle timeout or a full buffer, and an interrupt is raised.

---
 rtl/pulse_receiver_pkg.sv | 51 +++++
 rtl/pulse_receiver_input_conditioner.sv | 67 ++++++
 rtl/tqvp_hx2003_pulse_receiver.sv | 241 ++++++++++++++++++++++++
 tb/tb_tqvp_hx2003_pulse_receiver.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_receiver_pkg.sv
// ============================================================================
// Module   : pulse_receiver_pkg
// Purpose  : Shared types, register map and bit positions for the pulse
//            receiver peripheral.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_RECEIVING = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_CONFIG = 6'h04;
  localparam logic [5:0] ADDR_STATUS = 6'h08;

  localparam logic [1:0] ACC_8    = 2'b00;
  localparam logic [1:0] ACC_16   = 2'b01;
  localparam logic [1:0] ACC_32   = 2'b10;
  localparam logic [1:0] ACC_NONE = 2'b11;

  localparam int CTRL_START_BIT   = 7;
  localparam int CTRL_IRQ_EN_LSB  = 8;
  localparam int CTRL_INVERT_BIT  = 11;
  localparam int CTRL_PIN_SEL_LSB = 12;
  localparam int CTRL_TIMEOUT_LSB = 16;

  localparam int FLAG_FRAME_DONE  = 0;
  localparam int FLAG_BUF_FULL    = 1;
  localparam int FLAG_TIMEOUT_SAT = 2;

  localparam int         BUF_WORDS   = 8;
  localparam logic [7:0] BUF_SYMBOLS = 8'd128;
  localparam logic [7:0] DUR_MAX     = 8'hFF;

  // Symbol = {level, long}; long when the period strictly exceeds the level's threshold
  function automatic logic [1:0] classify(input logic       level,
                                          input logic [7:0] dur,
                                          input logic [7:0] thr_low,
                                          input logic [7:0] thr_high);
    return {level, (dur > (level ? thr_high : thr_low))};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_receiver_input_conditioner.sv
// ============================================================================
// Module   : pulse_receiver_input_conditioner
// Purpose  : Selects and optionally inverts one input pin, then produces a
//            registered level and a one-cycle edge pulse.
//            Optional macro: PULSE_RECEIVER_GLITCH_FILTER_EN (4-clock filter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_receiver_input_conditioner (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pin_i,
  input  logic [2:0] sel_i,
  input  logic       invert_i,
  output logic       level_o,
  output logic       edge_o
);

  logic w_pin;
  logic level_q;
  logic edge_q;

  assign w_pin = pin_i[sel_i] ^ invert_i;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  logic [1:0] stable_cnt_q;

  // A new level is accepted on its fourth consecutive sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q      <= 1'b0;
      edge_q       <= 1'b0;
      stable_cnt_q <= 2'd0;
    end else begin
      edge_q <= 1'b0;
      if (w_pin != level_q) begin
        if (stable_cnt_q == 2'd3) begin
          level_q      <= w_pin;
          edge_q       <= 1'b1;
          stable_cnt_q <= 2'd0;
        end else begin
          stable_cnt_q <= stable_cnt_q + 2'd1;
        end
      end else begin
        stable_cnt_q <= 2'd0;
      end
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= w_pin;
      edge_q  <= w_pin ^ level_q;
    end
  end
`endif

  assign level_o = level_q;
  assign edge_o  = edge_q;

endmodule

`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// ============================================================================
// Module   : tqvp_hx2003_pulse_receiver
// Purpose  : TinyQV peripheral decoding a pulse train into 2-bit symbols
//            stored in a 128-symbol buffer, with idle timeout and interrupt.
//            Optional macro: PULSE_RECEIVER_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tqvp_hx2003_pulse_receiver
  import pulse_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  state_e      state_q, state_d;
  logic [2:0]  flags_q, flags_d;
  logic        start_q, start_d;
  logic [2:0]  irq_en_q, irq_en_d;
  logic        invert_q, invert_d;
  logic [2:0]  pin_sel_q, pin_sel_d;
  logic [15:0] idle_timeout_q, idle_timeout_d;
  logic [3:0]  prescaler_q, prescaler_d;
  logic [7:0]  thr_low_q, thr_low_d;
  logic [7:0]  thr_high_q, thr_high_d;
  logic [7:0]  sym_count_q, sym_count_d;
  logic [7:0]  duration_q, duration_d;
  logic [7:0]  last_dur_q, last_dur_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic        level_q, level_d;
  logic [31:0] sym_buf_q [BUF_WORDS];

  logic        w_level;
  logic        w_edge;
  logic        w_tick;
  logic [15:0] w_tick_mask;
  logic        w_wr_ctrl;
  logic        w_wr_cfg;
  logic        w_wide;
  logic        w_full_width;
  logic [2:0]  w_w1c;
  logic [2:0]  w_flag_set;
  logic        w_sym_we;
  logic [1:0]  w_sym_val;
  logic        w_unused;

  pulse_receiver_input_conditioner u_cond (
    .clk_i    (clk),
    .rst_i    (rst),
    .pin_i    (ui_in),
    .sel_i    (pin_sel_q),
    .invert_i (invert_q),
    .level_o  (w_level),
    .edge_o   (w_edge)
  );

  assign w_tick_mask = (16'd1 << prescaler_q) - 16'd1;
  assign w_tick      = (presc_cnt_q & w_tick_mask) == w_tick_mask;

  assign w_wr_ctrl    = (data_write_n != ACC_NONE) && (address == ADDR_CTRL);
  assign w_wr_cfg     = (data_write_n != ACC_NONE) && (address == ADDR_CONFIG);
  assign w_wide       = (data_write_n == ACC_16) || (data_write_n == ACC_32);
  assign w_full_width = (data_write_n == ACC_32);
  assign w_w1c        = w_wr_ctrl ? data_in[2:0] : 3'b000;
  assign w_unused     = ^{data_read_n, data_in[15], data_in[6:3]};

  // Software-visible register file
  always_comb begin
    start_d        = start_q;
    irq_en_d       = irq_en_q;
    invert_d       = invert_q;
    pin_sel_d      = pin_sel_q;
    idle_timeout_d = idle_timeout_q;
    prescaler_d    = prescaler_q;
    thr_low_d      = thr_low_q;
    thr_high_d     = thr_high_q;
    if (w_wr_ctrl) begin
      start_d = data_in[CTRL_START_BIT];
      if (w_wide) begin
        irq_en_d  = data_in[CTRL_IRQ_EN_LSB +: 3];
        invert_d  = data_in[CTRL_INVERT_BIT];
        pin_sel_d = data_in[CTRL_PIN_SEL_LSB +: 3];
      end
      if (w_full_width) idle_timeout_d = data_in[CTRL_TIMEOUT_LSB +: 16];
    end
    if (w_wr_cfg) begin
      prescaler_d = data_in[3:0];
      if (w_wide)       thr_low_d  = data_in[15:8];
      if (w_full_width) thr_high_d = data_in[23:16];
    end
  end

  // Frame state machine and duration datapath
  always_comb begin
    state_d     = state_q;
    sym_count_d = sym_count_q;
    duration_d  = duration_q;
    last_dur_d  = last_dur_q;
    idle_cnt_d  = idle_cnt_q;
    level_d     = level_q;
    presc_cnt_d = start_q ? presc_cnt_q + 16'd1 : 16'd0;
    w_flag_set  = 3'b000;
    w_sym_we    = 1'b0;
    w_sym_val   = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        sym_count_d = 8'd0;
        duration_d  = 8'd0;
        idle_cnt_d  = 16'd0;
        if (start_d) begin
          state_d = ST_ARMED;
          level_d = w_level;
        end
      end
      ST_ARMED: begin
        if (w_edge) begin
          state_d    = ST_RECEIVING;
          duration_d = 8'd0;
          idle_cnt_d = 16'd0;
          level_d    = w_level;
        end
      end
      ST_RECEIVING: begin
        if (w_tick) begin
          duration_d = (duration_q == DUR_MAX) ? duration_q : duration_q + 8'd1;
          idle_cnt_d = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
        end
        if (w_edge || ((idle_timeout_q != 16'd0) && (idle_cnt_q == idle_timeout_q))) begin
          w_sym_we    = 1'b1;
          w_sym_val   = classify(level_q, duration_q, thr_low_q, thr_high_q);
          last_dur_d  = duration_q;
          sym_count_d = sym_count_q + 8'd1;
          if (sym_count_q == BUF_SYMBOLS - 8'd1) begin
            w_flag_set[FLAG_BUF_FULL]   = 1'b1;
            w_flag_set[FLAG_FRAME_DONE] = 1'b1;
            state_d                     = ST_DONE;
          end
        end
        if (w_edge) begin
          duration_d = 8'd0;
          idle_cnt_d = 16'd0;
          level_d    = w_level;
        end else if ((idle_timeout_q != 16'd0) && (idle_cnt_q == idle_timeout_q)) begin
          w_flag_set[FLAG_FRAME_DONE]  = 1'b1;
          w_flag_set[FLAG_TIMEOUT_SAT] = (duration_q == DUR_MAX);
          state_d                      = ST_DONE;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping start abandons the frame without touching buffer or flags
    if (!start_d) begin
      state_d    = ST_IDLE;
      w_sym_we   = 1'b0;
      w_flag_set = 3'b000;
    end

    flags_d = (flags_q & ~w_w1c) | w_flag_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      flags_q        <= 3'b000;
      start_q        <= 1'b0;
      irq_en_q       <= 3'b000;
      invert_q       <= 1'b0;
      pin_sel_q      <= 3'd0;
      idle_timeout_q <= 16'd0;
      prescaler_q    <= 4'd0;
      thr_low_q      <= 8'd0;
      thr_high_q     <= 8'd0;
      sym_count_q    <= 8'd0;
      duration_q     <= 8'd0;
      last_dur_q     <= 8'd0;
      idle_cnt_q     <= 16'd0;
      presc_cnt_q    <= 16'd0;
      level_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      flags_q        <= flags_d;
      start_q        <= start_d;
      irq_en_q       <= irq_en_d;
      invert_q       <= invert_d;
      pin_sel_q      <= pin_sel_d;
      idle_timeout_q <= idle_timeout_d;
      prescaler_q    <= prescaler_d;
      thr_low_q      <= thr_low_d;
      thr_high_q     <= thr_high_d;
      sym_count_q    <= sym_count_d;
      duration_q     <= duration_d;
      last_dur_q     <= last_dur_d;
      idle_cnt_q     <= idle_cnt_d;
      presc_cnt_q    <= presc_cnt_d;
      level_q        <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_WORDS; i++) sym_buf_q[i] <= 32'd0;
    end else if (w_sym_we) begin
      sym_buf_q[sym_count_q[6:4]][{sym_count_q[3:0], 1'b0} +: 2] <= w_sym_val;
    end
  end

  always_comb begin
    data_out = 32'd0;
    if (address == ADDR_CTRL) begin
      data_out = {idle_timeout_q, 1'b0, pin_sel_q, invert_q, irq_en_q, start_q, 4'b0000, flags_q};
    end else if (address == ADDR_CONFIG) begin
      data_out = {sym_count_q, thr_high_q, thr_low_q, 4'b0000, prescaler_q};
    end else if (address == ADDR_STATUS) begin
      data_out = {22'd0, state_q, last_dur_q};
    end else if (address[5] && (address[1:0] == 2'b00)) begin
      data_out = sym_buf_q[address[4:2]];
    end
  end

  assign uo_out         = {5'b00000, (state_q == ST_RECEIVING), w_level, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = |(flags_q & irq_en_q);

endmodule

`default_nettype wire

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// ============================================================================
// Module   : tb_tqvp_hx2003_pulse_receiver
// Purpose  : Self-checking bench for the pulse receiver, scoreboard of
//            expected symbols compared against the buffer read-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tqvp_hx2003_pulse_receiver;

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  localparam int LAT     = 3;
  localparam int PULSE_W = 5;
`else
  localparam int LAT     = 0;
  localparam int PULSE_W = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_q [$];
  logic       m_level;
  bit         m_started;
  int         m_count;
  int         m_seg;
  int         m_thr_lo;
  int         m_thr_hi;

  always #5 clk = ~clk;

  tqvp_hx2003_pulse_receiver dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address      = a;
    data_in      = d;
    data_write_n = wn;
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] v);
    address     = a;
    data_read_n = 2'b10;
    #1;
    v           = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic start_frame(input logic [3:0] presc, input logic [7:0] tlo, input logic [7:0] thi,
                             input logic [15:0] tmo, input logic [2:0] en);
    ui_in = 8'h00;
    repeat (6) @(posedge clk);
    #1;
    bus_write(6'h00, 32'h0000_0007, 2'b10);
    bus_write(6'h04, {8'h00, thi, tlo, 4'h0, presc}, 2'b10);
    bus_write(6'h00, {tmo, 1'b0, 3'd0, 1'b0, en, 1'b1, 4'b0000, 3'b111}, 2'b10);
    m_level   = 1'b0;
    m_started = 0;
    m_count   = 0;
    m_seg     = 0;
    m_thr_lo  = int'(tlo);
    m_thr_hi  = int'(thi);
    exp_q.delete();
  endtask

  // Holds pin 0 at lvl for n clocks, pushing the symbol of the period it ends
  task automatic drive_level(input logic lvl, input int n);
    int dur;
    if (lvl !== m_level) begin
      if (m_started && m_count < 128) begin
        dur = (m_seg - 1 > 255) ? 255 : m_seg - 1;
        exp_q.push_back({m_level, (dur > (m_level ? m_thr_hi : m_thr_lo))});
        m_count++;
      end
      m_started = 1;
      m_level   = lvl;
      m_seg     = 0;
    end
    ui_in[0] = lvl;
    repeat (n) @(posedge clk);
    #1;
    m_seg += n;
  endtask

  task automatic push_timeout(input int t);
    int dur;
    dur = (t > 255) ? 255 : t;
    exp_q.push_back({m_level, (dur > (m_level ? m_thr_hi : m_thr_lo))});
    m_count++;
  endtask

  task automatic wait_flag(input int bit_idx, input int max_cycles, input string tag);
    logic [31:0] v;
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      bus_read(6'h00, v);
      if (v[bit_idx]) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_wait: flag %0d still 0 after %0d cycles, required 1", tag, bit_idx, max_cycles);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_scoreboard(input string tag);
    logic [31:0] v;
    logic [1:0]  e;
    logic [1:0]  got;
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus_read(6'(32 + 4 * (k / 16)), v);
      got = v[2 * (k % 16) +: 2];
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s_sym%0d: got %0d required %0d", tag, k, got, e);
      end
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    ui_in = 8'h00;
    address = 6'h00;
    data_in = 32'h0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (uo_out !== 8'h00) begin n_bad++; $display("FAIL reset_uo_out: got %h required 00", uo_out); end
    n_cmp++;
    if (user_interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b required 0", user_interrupt); end
    n_cmp++;
    if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_data_out: got %h required 0", data_out); end
    n_cmp++;
    if (data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_data_ready: got %b required 1", data_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus_read(6'h08, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h required 0", v); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_short_frame();
    logic [31:0] v;
    start_frame(4'd0, 8'd10, 8'd10, 16'd50, 3'b001);
    drive_level(1'b1, 5);
    n_cmp++;
    if (uo_out !== 8'h06) begin n_bad++; $display("FAIL frame_uo_out: got %h required 06", uo_out); end
    n_cmp++;
    if (user_interrupt !== 1'b0) begin n_bad++; $display("FAIL frame_irq_early: got %b required 0", user_interrupt); end
    drive_level(1'b0, 20);
    drive_level(1'b1, 15);
    drive_level(1'b0, 1);
    wait_flag(0, 200, "frame");
    push_timeout(50);
    bus_read(6'h00, v);
    n_cmp++;
    if (v[2:0] !== 3'b001) begin n_bad++; $display("FAIL frame_flags: got %b required 001", v[2:0]); end
    bus_read(6'h04, v);
    n_cmp++;
    if (v[31:24] !== 8'd4) begin n_bad++; $display("FAIL frame_count: got %0d required 4", v[31:24]); end
    bus_read(6'h08, v);
    n_cmp++;
    if (v[9:0] !== {2'd3, 8'd50}) begin n_bad++; $display("FAIL frame_status: got %h required 332", v[9:0]); end
    n_cmp++;
    if (user_interrupt !== 1'b1) begin n_bad++; $display("FAIL frame_irq: got %b required 1", user_interrupt); end
    drain_scoreboard("frame");
  endtask

  task automatic test_buffer_full();
    logic [31:0] v;
    start_frame(4'd0, 8'd10, 8'd10, 16'd0, 3'b000);
    for (int i = 0; i < 132; i++) drive_level((i % 2 == 0) ? 1'b1 : 1'b0, PULSE_W);
    repeat (8) @(posedge clk);
    #1;
    bus_read(6'h00, v);
    n_cmp++;
    if (v[2:0] !== 3'b011) begin n_bad++; $display("FAIL full_flags: got %b required 011", v[2:0]); end
    bus_read(6'h04, v);
    n_cmp++;
    if (v[31:24] !== 8'd128) begin n_bad++; $display("FAIL full_count: got %0d required 128", v[31:24]); end
    bus_read(6'h08, v);
    n_cmp++;
    if (v[9:8] !== 2'd3) begin n_bad++; $display("FAIL full_state: got %0d required 3", v[9:8]); end
    drain_scoreboard("full");
  endtask

  task automatic test_saturation();
    logic [31:0] v;
    start_frame(4'd2, 8'd10, 8'd200, 16'd400, 3'b100);
    drive_level(1'b1, 1);
    wait_flag(0, 2500, "sat");
    push_timeout(400);
    bus_read(6'h00, v);
    n_cmp++;
    if (v[2:0] !== 3'b101) begin n_bad++; $display("FAIL sat_flags: got %b required 101", v[2:0]); end
    bus_read(6'h08, v);
    n_cmp++;
    if (v[7:0] !== 8'd255) begin n_bad++; $display("FAIL sat_duration: got %0d required 255", v[7:0]); end
    n_cmp++;
    if (user_interrupt !== 1'b1) begin n_bad++; $display("FAIL sat_irq: got %b required 1", user_interrupt); end
    drain_scoreboard("sat");
  endtask

  task automatic test_w1c_collision();
    logic [31:0] v;
    start_frame(4'd0, 8'd10, 8'd10, 16'd20, 3'b000);
    drive_level(1'b1, 5);
    ui_in[0] = 1'b0;
    repeat (20 + 2 + LAT) @(posedge clk);
    #1;
    bus_write(6'h00, 32'h0000_0081, 2'b00);
    bus_read(6'h00, v);
    n_cmp++;
    if (v[0] !== 1'b1) begin n_bad++; $display("FAIL w1c_collide: got %b required 1", v[0]); end
    bus_read(6'h08, v);
    n_cmp++;
    if (v[9:8] !== 2'd3) begin n_bad++; $display("FAIL w1c_state: got %0d required 3", v[9:8]); end
    bus_write(6'h00, 32'h0000_0081, 2'b00);
    bus_read(6'h00, v);
    n_cmp++;
    if (v[7:0] !== 8'h80) begin n_bad++; $display("FAIL w1c_clear: got %h required 80", v[7:0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    start_frame(4'd0, 8'd10, 8'd10, 16'd0, 3'b111);
    drive_level(1'b1, 5);
    drive_level(1'b0, 5);
    n_cmp++;
    if (uo_out[2] !== 1'b1) begin n_bad++; $display("FAIL arst_receiving: got %b required 1", uo_out[2]); end
    #2;
    rst = 1'b1;
    address = 6'h00;
    #1;
    n_cmp++;
    if (uo_out !== 8'h00) begin n_bad++; $display("FAIL arst_uo_out: got %h required 00", uo_out); end
    n_cmp++;
    if (user_interrupt !== 1'b0) begin n_bad++; $display("FAIL arst_irq: got %b required 0", user_interrupt); end
    bus_read(6'h00, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL arst_ctrl: got %h required 0", v); end
    bus_read(6'h08, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL arst_status: got %h required 0", v); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    logic [31:0] v;
    start_frame(4'd0, 8'd10, 8'd10, 16'd30, 3'b000);
    drive_level(1'b1, 6);
    ui_in[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ui_in[0] = 1'b1;
    m_seg += 2;
    drive_level(1'b1, 10);
    drive_level(1'b0, 1);
    wait_flag(0, 200, "glitch");
    push_timeout(30);
    bus_read(6'h04, v);
    n_cmp++;
    if (v[31:24] !== 8'd2) begin n_bad++; $display("FAIL glitch_count: got %0d required 2", v[31:24]); end
    drain_scoreboard("glitch");
  endtask
`endif

  initial begin
    test_reset();
    test_short_frame();
    test_buffer_full();
    test_saturation();
    test_w1c_collision();
    test_async_reset();
`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
